mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

CPU-side initiator for the 512×32 word-addressed RAM. Holds the MAR and MDR and sequences a read or write handshake onto the RAM's `read`/`write`/`address`/data ports, with a configurable access time. It keeps address and write data stable for the entire time `write` is high, because the RAM writes level-sensitively. The control unit issues single-cycle requests and waits for `done`. Read data lands in MDR and is driven to the bus mux via `MDRout`.

## Interface
- `WAIT_CYCLES`, 1, number of cycles `mem_read`/`mem_write` are held high per access (legal 1..15)
- `clock` in 1: sole clock, rising edge
- `clear` in 1: asynchronous, active-low reset
- `BusMuxOut` in 32: CPU bus value
- `MARin` in 1: load MAR <= BusMuxOut[8:0]; ignored while busy
- `MDRin` in 1: load MDR <= BusMuxOut; ignored while busy
- `rd_req` in 1: start read at MAR (sampled in IDLE)
- `wr_req` in 1: start write of MDR to MAR (sampled in IDLE)
- `Mdatain` in 32: RAM read data
- `mem_read` out 1: RAM read strobe, registered
- `mem_write` out 1: RAM write strobe, registered
- `mem_address` out 9: equals MAR
- `mem_wdata` out 32: equals MDR
- `MDRout` out 32: equals MDR
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle completion pulse
- `req_err` out 1: one-cycle pulse, rejected request

## Operation
- States: IDLE, RD_ACCESS, RD_DONE, WR_SETUP, WR_STROBE, WR_DONE. The wait counter is 4 bits.
- IDLE:
  - MARin and MDRin load on the clock edge.
  - A request sampled on the same edge as MARin uses the newly loaded MAR.
  - rd_req alone → RD_ACCESS. wr_req alone → WR_SETUP.
- RD_ACCESS:
  - mem_read=1 for WAIT_CYCLES cycles.
  - On the final edge, MDR <= Mdatain → RD_DONE.
- RD_DONE: mem_read=0, done=1 → IDLE.
- WR_SETUP: mem_address and mem_wdata are driven, mem_write=0 for one cycle → WR_STROBE.
- WR_STROBE: mem_write=1 for WAIT_CYCLES cycles → WR_DONE.
- WR_DONE: mem_write=0, address and data still held, done=1 → IDLE.
- mem_read and mem_write are never high together.
- MAR and MDR are frozen while busy. Exception: the MDR capture at the end of RD_ACCESS.
- Boundary conditions:
  - rd_req and wr_req together in IDLE: both ignored, req_err=1 next cycle, state stays IDLE.
  - Any request while busy: ignored, req_err=1 next cycle, the current access is unaffected.
  - MARin/MDRin while busy: no effect.
  - MAR takes BusMuxOut[8:0] only; upper bits are discarded. There is no wrap-around logic because the address space is exactly 512 words.

## Timing
- Reset (clear=0, asynchronous, no clock needed):
  - State IDLE, MAR=0, MDR=0, counter=0.
  - All outputs 0: mem_read, mem_write, busy, done, req_err, mem_address, mem_wdata, MDRout.
- Reset mid-operation: the strobe drops immediately and MDR is cleared. RAM contents already written during WR_STROBE are not restored.
- Read, with the request sampled at edge 0:
  - mem_read high in cycles 1..W.
  - MDR valid and done high in cycle W+1.
  - busy high in cycles 1..W+1.
  - The next request is accepted at edge W+2.
- Write, with the request sampled at edge 0:
  - Setup in cycle 1.
  - mem_write high in cycles 2..W+1.
  - done in cycle W+2.
  - busy high in cycles 1..W+2.
- Address and data are stable from one cycle before mem_write rises until one cycle after it falls.
- All outputs are registered or direct register taps; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert clear=0 mid-cycle → all outputs 0 without a clock edge. Release → IDLE, busy=0.
- Write then read, W=1:
  - MARin with bus 0x0000_0055, then MDRin with 0xDEADBEEF, then wr_req.
  - → mem_address=0x055 and mem_wdata=0xDEADBEEF for cycles 1–3; mem_write high only in cycle 2; done in cycle 3.
  - Then rd_req → mem_read high in cycle 1, MDRout=0xDEADBEEF and done in cycle 2.
- W=3 read plus truncation:
  - MARin with bus 0xFFFF_FE03 → mem_address=0x003.
  - rd_req → mem_read high for exactly 3 cycles, done in cycle 4.
- Request while busy: wr_req in cycle 1 of a read → req_err pulse, mem_write stays 0 throughout, read completes with correct data.
- Simultaneous rd_req+wr_req in IDLE → req_err pulse next cycle, busy stays 0, no strobes.
- Reset mid-strobe, W=3: drive clear=0 in the second WR_STROBE cycle → mem_write=0 and busy=0 immediately, MDR=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the 512x32 word-addressed RAM: holds MAR/MDR and sequences
// read/write handshakes with a WAIT_CYCLES-long strobe.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] BusMuxOut,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] Mdatain,
    output logic        mem_read,
    output logic        mem_write,
    output logic [8:0]  mem_address,
    output logic [31:0] mem_wdata,
    output logic [31:0] MDRout,
    output logic        busy,
    output logic        done,
    output logic        req_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        RD_DONE,
        WR_SETUP,
        WR_STROBE,
        WR_DONE
    } StateType;

    localparam logic [3:0] LOAD_COUNT = 4'(WAIT_CYCLES - 1);

    StateType    r_state;
    StateType    w_nextState;
    logic [3:0]  r_count;
    logic [8:0]  r_mar;
    logic [31:0] r_mdr;
    logic        r_memRead;
    logic        r_memWrite;
    logic        r_busy;
    logic        r_done;
    logic        r_reqErr;
    logic        w_idle;
    logic        w_capture;
    logic        w_reqErr;
    logic        w_enterTimed;

    assign w_idle = (r_state == IDLE);

    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_req && !wr_req) begin
                    w_nextState = RD_ACCESS;
                end else if (wr_req && !rd_req) begin
                    w_nextState = WR_SETUP;
                end
            end
            RD_ACCESS: begin
                if (r_count == 4'd0) begin
                    w_nextState = RD_DONE;
                    w_capture   = 1'b1;
                end
            end
            RD_DONE:   w_nextState = IDLE;
            WR_SETUP:  w_nextState = WR_STROBE;
            WR_STROBE: begin
                if (r_count == 4'd0) begin
                    w_nextState = WR_DONE;
                end
            end
            WR_DONE:   w_nextState = IDLE;
            default:   w_nextState = IDLE;
        endcase
    end

    // Both requests at once in IDLE, or any request while an access is running, is rejected.
    assign w_reqErr = w_idle ? (rd_req && wr_req) : (rd_req || wr_req);

    assign w_enterTimed = (w_nextState != r_state) &&
                          ((w_nextState == RD_ACCESS) || (w_nextState == WR_STROBE));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_nextState;
            if (w_enterTimed) begin
                r_count <= LOAD_COUNT;
            end else if ((r_state == RD_ACCESS || r_state == WR_STROBE) && r_count != 4'd0) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    // MAR/MDR load only in IDLE so address and data stay put for the whole write strobe.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_mar <= 9'd0;
            r_mdr <= 32'd0;
        end else begin
            if (w_idle && MARin) begin
                r_mar <= BusMuxOut[8:0];
            end
            if (w_capture) begin
                r_mdr <= Mdatain;
            end else if (w_idle && MDRin) begin
                r_mdr <= BusMuxOut;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_reqErr   <= 1'b0;
        end else begin
            r_memRead  <= (w_nextState == RD_ACCESS);
            r_memWrite <= (w_nextState == WR_STROBE);
            r_busy     <= (w_nextState != IDLE);
            r_done     <= (w_nextState == RD_DONE) || (w_nextState == WR_DONE);
            r_reqErr   <= w_reqErr;
        end
    end

    assign mem_read    = r_memRead;
    assign mem_write   = r_memWrite;
    assign mem_address = r_mar;
    assign mem_wdata   = r_mdr;
    assign MDRout      = r_mdr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign req_err     = r_reqErr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: W=1 and W=3 instances share stimulus and are compared every
// cycle against a timeline model of each access plus a behavioural RAM.
module tb_mem_access_ctrl;

    localparam int NINST = 2;
    localparam int WV[NINST] = '{1, 3};

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] busMuxOut;
    logic        marIn, mdrIn, rdReq, wrReq;

    logic [31:0] mdatain1, mdatain3;
    logic        memRead1, memWrite1, busy1, done1, reqErr1;
    logic        memRead3, memWrite3, busy3, done3, reqErr3;
    logic [8:0]  memAddress1, memAddress3;
    logic [31:0] memWdata1, memWdata3, mdrOut1, mdrOut3;

    logic [31:0] ram1[512];
    logic [31:0] ram3[512];

    // Model: per instance, MAR/MDR, the kind of the last access (0 none, 1 read, 2 write)
    // and the edge on which it was accepted; outputs follow from cycle offsets.
    logic [8:0]  mMar[NINST];
    logic [31:0] mMdr[NINST];
    int          mKind[NINST];
    int          mStart[NINST];
    logic        mErr[NINST];
    logic [31:0] mRam[NINST][512];
    logic        eRead[NINST], eWrite[NINST], eBusy[NINST], eDone[NINST];

    int edgeNum = 0;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign mdatain1 = ram1[memAddress1];
    assign mdatain3 = ram3[memAddress3];

    mem_access_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clock(clock), .clear(clear), .BusMuxOut(busMuxOut), .MARin(marIn), .MDRin(mdrIn),
        .rd_req(rdReq), .wr_req(wrReq), .Mdatain(mdatain1), .mem_read(memRead1),
        .mem_write(memWrite1), .mem_address(memAddress1), .mem_wdata(memWdata1),
        .MDRout(mdrOut1), .busy(busy1), .done(done1), .req_err(reqErr1)
    );

    mem_access_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .clock(clock), .clear(clear), .BusMuxOut(busMuxOut), .MARin(marIn), .MDRin(mdrIn),
        .rd_req(rdReq), .wr_req(wrReq), .Mdatain(mdatain3), .mem_read(memRead3),
        .mem_write(memWrite3), .mem_address(memAddress3), .mem_wdata(memWdata3),
        .MDRout(mdrOut3), .busy(busy3), .done(done3), .req_err(reqErr3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int lastCycle(input int i);
        return mStart[i] + WV[i] + ((mKind[i] == 2) ? 2 : 1);
    endfunction

    function automatic bit busyAt(input int i, input int c);
        return (mKind[i] != 0) && (c >= mStart[i] + 1) && (c <= lastCycle(i));
    endfunction

    task automatic computeExpected(input int c);
        for (int i = 0; i < NINST; i++) begin
            eBusy[i]  = busyAt(i, c);
            eRead[i]  = (mKind[i] == 1) && (c >= mStart[i] + 1) && (c <= mStart[i] + WV[i]);
            eWrite[i] = (mKind[i] == 2) && (c >= mStart[i] + 2) && (c <= mStart[i] + WV[i] + 1);
            eDone[i]  = (mKind[i] != 0) && (c == lastCycle(i));
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NINST; i++) begin
            mMar[i]   = 9'd0;
            mMdr[i]   = 32'd0;
            mKind[i]  = 0;
            mStart[i] = -100;
            mErr[i]   = 1'b0;
        end
        computeExpected(edgeNum);
    endtask

    // Called right after each rising edge; the inputs seen are those driven before it.
    task automatic modelEdge();
        edgeNum++;
        if (clear) begin
            for (int i = 0; i < NINST; i++) begin
                if (mKind[i] == 1 && edgeNum == mStart[i] + WV[i]) mMdr[i] = mRam[i][mMar[i]];
                if (mKind[i] == 2 && edgeNum == mStart[i] + 2) mRam[i][mMar[i]] = mMdr[i];
                if (busyAt(i, edgeNum)) begin
                    mErr[i] = rdReq || wrReq;
                end else begin
                    mErr[i] = rdReq && wrReq;
                    if (marIn) mMar[i] = busMuxOut[8:0];
                    if (mdrIn) mMdr[i] = busMuxOut;
                    if (rdReq && !wrReq) begin
                        mKind[i] = 1;
                        mStart[i] = edgeNum;
                    end else if (wrReq && !rdReq) begin
                        mKind[i] = 2;
                        mStart[i] = edgeNum;
                    end
                end
            end
        end
        computeExpected(edgeNum + 1);
    endtask

    task automatic checkInstance(input string nm, input int i, input logic r, input logic w,
                                 input logic [8:0] a, input logic [31:0] wd, input logic [31:0] md,
                                 input logic b, input logic d, input logic e);
        checkOutput({nm, ".mem_read"},    {31'd0, r}, {31'd0, eRead[i]});
        checkOutput({nm, ".mem_write"},   {31'd0, w}, {31'd0, eWrite[i]});
        checkOutput({nm, ".mem_address"}, {23'd0, a}, {23'd0, mMar[i]});
        checkOutput({nm, ".mem_wdata"},   wd, mMdr[i]);
        checkOutput({nm, ".MDRout"},      md, mMdr[i]);
        checkOutput({nm, ".busy"},        {31'd0, b}, {31'd0, eBusy[i]});
        checkOutput({nm, ".done"},        {31'd0, d}, {31'd0, eDone[i]});
        checkOutput({nm, ".req_err"},     {31'd0, e}, {31'd0, mErr[i]});
    endtask

    task automatic checkAll();
        checkInstance("W1", 0, memRead1, memWrite1, memAddress1, memWdata1, mdrOut1, busy1, done1, reqErr1);
        checkInstance("W3", 1, memRead3, memWrite3, memAddress3, memWdata3, mdrOut3, busy3, done3, reqErr3);
    endtask

    task automatic applyStimulus(input logic ma, input logic md, input logic rd, input logic wr,
                                 input logic [31:0] bus);
        marIn     = ma;
        mdrIn     = md;
        rdReq     = rd;
        wrReq     = wr;
        busMuxOut = bus;
    endtask

    // The RAM writes level-sensitively while mem_write is high; servicing it mid-cycle avoids edge races.
    task automatic cycleStep();
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        checkAll();
        if (memWrite1) ram1[memAddress1] = memWdata1;
        if (memWrite3) ram3[memAddress3] = memWdata3;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
            cycleStep();
        end
    endtask

    task automatic midCycleReset();
        #2 clear = 1'b0;
        #1 modelReset();
        checkAll();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
        cycleStep();
        clear = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            logic [31:0] v;
            v = $urandom;
            ram1[i] = v;
            ram3[i] = v;
            for (int j = 0; j < NINST; j++) mRam[j][i] = v;
        end

        clear = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        modelReset();
        #3 checkAll();
        cycleStep();
        clear = 1'b1;
        idleCycles(2);

        // Write 0xDEADBEEF to 0x055, then read it back.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0055);
        cycleStep();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        cycleStep();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, $urandom);
        cycleStep();
        checkOutput("wr.W1.setup_addr", {23'd0, memAddress1}, 32'h055);
        idleCycles(6);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, $urandom);
        cycleStep();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, $urandom);
        cycleStep();
        checkOutput("rd.W1.MDRout", mdrOut1, 32'hDEAD_BEEF);
        checkOutput("rd.W1.done", {31'd0, done1}, 32'd1);
        idleCycles(6);

        // MAR truncation plus a read, with MAR load and request on the same edge.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FE03);
        cycleStep();
        checkOutput("trunc.W3.addr", {23'd0, memAddress3}, 32'h003);
        idleCycles(6);

        // Write request, MARin and MDRin while a read is running.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, $urandom);
        cycleStep();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_01FF);
        cycleStep();
        idleCycles(6);

        // Simultaneous requests in IDLE.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, $urandom);
        cycleStep();
        idleCycles(3);

        for (int n = 0; n < 500; n++) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom);
            cycleStep();
        end
        idleCycles(8);

        // Reset in the second strobe cycle of a W=3 write.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0123);
        cycleStep();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);
        cycleStep();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, $urandom);
        cycleStep();
        idleCycles(2);
        checkOutput("rst.W3.pre_write", {31'd0, memWrite3}, 32'd1);
        midCycleReset();
        checkOutput("rst.W3.mem_write", {31'd0, memWrite3}, 32'd0);
        checkOutput("rst.W3.MDRout", mdrOut3, 32'd0);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0123);
        cycleStep();
        idleCycles(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
